// File: rtl/delqa_pkg.sv
`default_nettype none
// ============================================================================
// Package     : delqa_pkg
// Description : Shared types and constants for the DELQA descriptor engines:
//               write-back FSM state encoding, operation codes, descriptor
//               word byte offsets, BDL register-file indices and the
//               "in use" flag value.
// Revision    : 1.0 - initial release
// ============================================================================
package delqa_pkg;

    // Write-back engine states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_LOAD = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } wb_state_t;

    // Operation requested by the descriptor sequencer
    localparam logic C_OP_FLAG   = 1'b0;
    localparam logic C_OP_STATUS = 1'b1;

    // Byte offsets of the descriptor words inside one buffer descriptor
    localparam logic [3:0] C_OFF_FLAG  = 4'd0;
    localparam logic [3:0] C_OFF_ADDRH = 4'd2;
    localparam logic [3:0] C_OFF_ADDRL = 4'd4;
    localparam logic [3:0] C_OFF_LEN   = 4'd6;
    localparam logic [3:0] C_OFF_SW1   = 4'd8;
    localparam logic [3:0] C_OFF_SW2   = 4'd10;

    // BDL register-file indices of the status words
    localparam logic [1:0] C_IDX_SW1 = 2'd2;
    localparam logic [1:0] C_IDX_SW2 = 2'd3;

    // Value posted into the flag word to mark a descriptor as in use
    localparam logic [15:0] C_FLAG_INUSE = 16'hC000;

    // Byte offset of word 'idx' of an operation. STATUS posts SW2 first and
    // SW1 last, because the host polls SW1[15:14] to detect completion.
    function automatic logic [3:0] wb_word_offset(input logic op, input logic idx);
        logic [3:0] off;
        off = C_OFF_FLAG;
        if (op == C_OP_STATUS) begin
            off = idx ? C_OFF_SW1 : C_OFF_SW2;
        end
        return off;
    endfunction

    // Register-file index that supplies word 'idx' of an operation
    function automatic logic [1:0] wb_word_reg(input logic op, input logic idx);
        logic [1:0] ri;
        ri = 2'd0;
        if (op == C_OP_STATUS) begin
            ri = idx ? C_IDX_SW1 : C_IDX_SW2;
        end
        return ri;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bdl_wb_if.sv
`default_nettype none
// ============================================================================
// Interface   : bdl_wb_if
// Description : Q-bus DMA master write channel used by the BDL write-back
//               engine.
//   dma_req  : bus request (master -> slave)
//   dma_gnt  : bus grant (slave -> master)
//   dma_addr : byte write address, AW bits (master -> slave)
//   dma_dat  : 16-bit write data (master -> slave)
//   dma_stb  : write strobe, held until acknowledged (master -> slave)
//   dma_ack  : one-cycle write acknowledge (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface bdl_wb_if #(
    parameter int AW = 22
) ();
    logic          dma_req;
    logic          dma_gnt;
    logic [AW-1:0] dma_addr;
    logic [15:0]   dma_dat;
    logic          dma_stb;
    logic          dma_ack;

    modport master (
        output dma_req,
        output dma_addr,
        output dma_dat,
        output dma_stb,
        input  dma_gnt,
        input  dma_ack
    );

    modport slave (
        input  dma_req,
        input  dma_addr,
        input  dma_dat,
        input  dma_stb,
        output dma_gnt,
        output dma_ack
    );
endinterface
`default_nettype wire

// File: rtl/bdl_wb_tmo.sv
`default_nettype none
// ============================================================================
// Module      : bdl_wb_tmo
// Description : Loadable down-counter that bounds the wait for a DMA
//               acknowledge.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   load   : reload the counter with TMO
//   en     : count down one step this cycle
//   expire : counter reaches zero at the end of this counting cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bdl_wb_tmo #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int c_w = 8;

    logic [c_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_w'(TMO);
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loaded with TMO, so the counter allows exactly TMO counting cycles:
    // the one that steps 1 -> 0 is the last. A zero count (never loaded)
    // also expires rather than waiting forever.
    assign expire = en && (r_cnt <= c_w'(1));

endmodule
`default_nettype wire

// File: rtl/bdl_wb.sv
`default_nettype none
// ============================================================================
// Module      : bdl_wb
// Description : DMA write-back engine for DELQA buffer descriptors. Reads
//               words from the local BDL register file and writes them to
//               host Q-bus memory. FLAG writes the in-use flag at base+0;
//               STATUS writes reg[3] at base+10 then reg[2] at base+8.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   start    : one-cycle request, accepted only when idle
//   op       : 0 = FLAG, 1 = STATUS (sampled with start)
//   base     : descriptor byte address (bit 0 ignored)
//   busy     : accepted start through done cycle inclusive
//   done     : one-cycle completion pulse
//   nxm      : acknowledge timeout, valid from done until next start
//   reg_addr : BDL register-file read index
//   reg_q    : BDL register-file read data (combinational read)
//   dma      : Q-bus DMA master write channel
// Revision    : 1.0 - initial release
// ============================================================================
module bdl_wb
    import delqa_pkg::*;
#(
    parameter int          AW         = 22,
    parameter int          TMO        = 255,
    parameter logic [15:0] FLAG_INUSE = C_FLAG_INUSE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op,
    input  logic [AW-1:0]   base,
    output logic            busy,
    output logic            done,
    output logic            nxm,
    output logic [1:0]      reg_addr,
    input  logic [15:0]     reg_q,
    bdl_wb_if.master        dma
);

    localparam logic [AW-1:0] c_even_mask = ~{{(AW-1){1'b0}}, 1'b1};

    wb_state_t     r_state;
    logic          r_op;
    logic [AW-1:0] r_base;
    logic          r_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_nxm;
    logic          r_req;
    logic          r_stb;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_dat;
    logic [1:0]    r_reg_addr;

    logic          w_last;
    logic          w_tmo_load;
    logic          w_tmo_en;
    logic          w_tmo_expire;

    // FLAG is a single word; STATUS ends after its second word
    assign w_last     = (r_op == C_OP_FLAG) || r_idx;
    assign w_tmo_load = (r_state == ST_LOAD);
    assign w_tmo_en   = (r_state == ST_WR);

    bdl_wb_tmo #(
        .TMO    (TMO)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_tmo_load),
        .en     (w_tmo_en),
        .expire (w_tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= C_OP_FLAG;
            r_base     <= '0;
            r_idx      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nxm      <= 1'b0;
            r_req      <= 1'b0;
            r_stb      <= 1'b0;
            r_addr     <= '0;
            r_dat      <= '0;
            r_reg_addr <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_base     <= base & c_even_mask;
                        r_idx      <= 1'b0;
                        r_nxm      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_req      <= 1'b1;
                        // Index is set up now so reg_q has settled by LOAD
                        r_reg_addr <= wb_word_reg(op, 1'b0);
                        r_state    <= ST_ARB;
                    end
                end

                ST_ARB: begin
                    if (dma.dma_gnt) begin
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (!dma.dma_gnt) begin
                        r_state <= ST_ARB;
                    end else begin
                        r_dat   <= (r_op == C_OP_FLAG) ? FLAG_INUSE : reg_q;
                        // Wraps modulo 2^AW by truncation
                        r_addr  <= r_base + {{(AW-4){1'b0}}, wb_word_offset(r_op, r_idx)};
                        r_stb   <= 1'b1;
                        r_state <= ST_WR;
                    end
                end

                ST_WR: begin
                    // Acknowledge takes priority over both grant loss and
                    // timer expiry in the same cycle.
                    if (dma.dma_ack) begin
                        r_stb <= 1'b0;
                        if (w_last) begin
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx      <= 1'b1;
                            r_reg_addr <= wb_word_reg(r_op, 1'b1);
                            r_state    <= ST_LOAD;
                        end
                    end else if (!dma.dma_gnt) begin
                        // Retry the same word after regrant; LOAD reloads the timer
                        r_stb   <= 1'b0;
                        r_state <= ST_ARB;
                    end else if (w_tmo_expire) begin
                        r_stb   <= 1'b0;
                        r_req   <= 1'b0;
                        r_nxm   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_stb   <= 1'b0;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign nxm          = r_nxm;
    assign reg_addr     = r_reg_addr;
    assign dma.dma_req  = r_req;
    assign dma.dma_stb  = r_stb;
    assign dma.dma_addr = r_addr;
    assign dma.dma_dat  = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_bdl_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bdl_wb
// Description : Self-checking bench for bdl_wb. Directed scenarios followed
//               by randomized operations, compared against a descriptor-level
//               model of the expected host-memory writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bdl_wb;
    import delqa_pkg::*;

    localparam int AW    = 22;
    localparam int c_tmo = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          op    = 1'b0;
    logic [AW-1:0] base  = '0;
    logic          busy;
    logic          done;
    logic          nxm;
    logic [1:0]    reg_addr;
    logic [15:0]   reg_q;
    logic [15:0]   regf [4];

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int acks     = 0;

    wr_t exp_q[$];

    bdl_wb_if #(.AW(AW)) dma ();

    assign reg_q = regf[reg_addr];

    bdl_wb #(
        .AW         (AW),
        .TMO        (c_tmo),
        .FLAG_INUSE (16'hC000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .base     (base),
        .busy     (busy),
        .done     (done),
        .nxm      (nxm),
        .reg_addr (reg_addr),
        .reg_q    (reg_q),
        .dma      (dma)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Host writes an operation must produce, in bus order
    function automatic void build_expect(input logic op_i, input logic [AW-1:0] b);
        int unsigned ub;
        int unsigned m;
        m  = 32'd1 << AW;
        ub = 32'(b) & ~32'd1;
        exp_q.delete();
        if (!op_i) begin
            exp_q.push_back('{a: AW'(ub % m), d: 16'hC000});
        end else begin
            exp_q.push_back('{a: AW'((ub + 10) % m), d: regf[3]});
            exp_q.push_back('{a: AW'((ub + 8) % m),  d: regf[2]});
        end
    endfunction

    task automatic hard_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        dma.dma_gnt = 1'b0;
        dma.dma_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns 1 if stb rose within the bound
    task automatic wait_stb(output bit ok);
        int k;
        k = 0;
        while (!dma.dma_stb && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = dma.dma_stb;
    endtask

    task automatic run_op(input logic op_i, input logic [AW-1:0] base_i,
                          input int gnt_dly, input int ack_dly,
                          input bit no_ack, input bit drop_gnt, input bit dup_start);
        int  t0;
        int  nw;
        int  a0;
        int  dc0;
        int  k;
        bit  ok;
        build_expect(op_i, base_i);
        nw = exp_q.size();
        @(negedge clk);
        a0    = acks;
        dc0   = done_cnt;
        op    = op_i;
        base  = base_i;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        base  = AW'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("nxm_cleared", 32'(nxm), 32'd0);
        check("req_after_start", 32'(dma.dma_req), 32'd1);
        if (dup_start) begin
            start = 1'b1;
            op    = ~op_i;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (gnt_dly) @(negedge clk);
        dma.dma_gnt = 1'b1;
        for (int w = 0; w < nw; w++) begin
            wait_stb(ok);
            if (!ok) begin
                check("stb_wait_timeout", 32'd0, 32'd1);
                hard_reset();
                return;
            end
            if (w == 0 && gnt_dly == 0 && !dup_start)
                check("stb_latency", 32'(cyc - t0), 32'd3);
            check("addr", 32'(dma.dma_addr), 32'(exp_q[w].a));
            check("dat", 32'(dma.dma_dat), 32'(exp_q[w].d));
            if (drop_gnt && w == nw - 1) begin
                dma.dma_gnt = 1'b0;
                @(negedge clk);
                check("stb_drop_gnt_loss", 32'(dma.dma_stb), 32'd0);
                check("req_held_retry", 32'(dma.dma_req), 32'd1);
                dma.dma_gnt = 1'b1;
                wait_stb(ok);
                if (!ok) begin
                    check("retry_stb_timeout", 32'd0, 32'd1);
                    hard_reset();
                    return;
                end
                check("retry_addr", 32'(dma.dma_addr), 32'(exp_q[w].a));
                check("retry_dat", 32'(dma.dma_dat), 32'(exp_q[w].d));
            end
            if (no_ack) begin
                k = 0;
                while (dma.dma_stb && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                check("stb_cycles_to_tmo", 32'(k), 32'(c_tmo));
                check("done_on_tmo", 32'(done), 32'd1);
                check("nxm_on_tmo", 32'(nxm), 32'd1);
                break;
            end
            for (int j = 0; j < ack_dly; j++) begin
                @(negedge clk);
                check("stb_held", 32'(dma.dma_stb), 32'd1);
                check("addr_stable", 32'(dma.dma_addr), 32'(exp_q[w].a));
            end
            dma.dma_ack = 1'b1;
            @(negedge clk);
            dma.dma_ack = 1'b0;
            acks++;
            if (w < nw - 1) begin
                check("stb_low_between", 32'(dma.dma_stb), 32'd0);
                check("req_between_words", 32'(dma.dma_req), 32'd1);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("nxm_on_ack", 32'(nxm), 32'd0);
                check("req_low_done", 32'(dma.dma_req), 32'd0);
                check("busy_in_done", 32'(busy), 32'd1);
                if (gnt_dly == 0 && ack_dly == 0 && nw == 1 && !dup_start && !drop_gnt)
                    check("done_latency", 32'(cyc - t0), 32'd4);
            end
        end
        @(negedge clk);
        dma.dma_gnt = 1'b0;
        check("busy_idle", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("nxm_held", 32'(nxm), 32'(no_ack));
        check("acks_per_op", 32'(acks - a0), no_ack ? 32'd0 : 32'(nw));
        repeat (3) @(negedge clk);
        check("no_spurious_req", 32'(dma.dma_req), 32'd0);
        check("done_count", 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        bit ok;
        int r;
        dma.dma_gnt = 1'b0;
        dma.dma_ack = 1'b0;
        for (int i = 0; i < 4; i++) regf[i] = 16'(i * 16'h1111);

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_nxm", 32'(nxm), 32'd0);
        check("rst_req", 32'(dma.dma_req), 32'd0);
        check("rst_stb", 32'(dma.dma_stb), 32'd0);
        check("rst_addr", 32'(dma.dma_addr), 32'd0);
        check("rst_dat", 32'(dma.dma_dat), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        run_op(C_OP_FLAG, 22'h001000, 0, 2, 1'b0, 1'b0, 1'b0);
        run_op(C_OP_FLAG, 22'h001001, 0, 0, 1'b0, 1'b0, 1'b0);
        regf[3] = 16'h1234;
        regf[2] = 16'h8000;
        run_op(C_OP_STATUS, 22'h3FFFF8, 1, 1, 1'b0, 1'b0, 1'b0);
        run_op(C_OP_STATUS, 22'h000200, 0, 0, 1'b1, 1'b0, 1'b0);
        run_op(C_OP_FLAG, 22'h000040, 0, 0, 1'b0, 1'b0, 1'b0);
        run_op(C_OP_STATUS, 22'h0ABCD0, 0, 1, 1'b0, 1'b1, 1'b0);
        run_op(C_OP_STATUS, 22'h012340, 0, c_tmo - 1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        op    = C_OP_STATUS;
        base  = 22'h000100;
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        dma.dma_gnt = 1'b1;
        wait_stb(ok);
        check("rst_mid_stb_seen", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_stb", 32'(dma.dma_stb), 32'd0);
        check("async_rst_req", 32'(dma.dma_req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        dma.dma_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(C_OP_FLAG, 22'h002000, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) regf[i] = 16'($urandom);
            r = int'($urandom_range(0, 9));
            run_op(1'($urandom), AW'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, c_tmo - 1)),
                   r == 0, r == 1, r == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
